operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage between decode and execute. Accepts one decoded instruction (rs1, rs2, pc), sequences up to two reads through the single-read-port register file, and presents both 32-bit source operands to execute over a valid/ready handshake. Register-file reads are dropped in any cycle where writeback asserts a write, so this block detects those dropped reads and retries them, or forwards the write data when configured to.

## Interface
- XLEN, 32, operand/data width
- REG_AW, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept
- in_rs1, in_rs2  in  REG_AW  source indices
- in_use_rs2  in  1  instruction needs rs2
- in_pc  in  XLEN  payload passed through
- rf_read_en  out  1  register-file read request
- rf_read_reg  out  REG_AW  read index
- rf_read_data  in  XLEN  register-file read data, valid the cycle after a successful read
- wb_en, wb_reg, wb_data  in  1/REG_AW/XLEN  writeback write, same signals the register file sees
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_rs1_data, out_rs2_data, out_pc  out  XLEN  operands and pc

## Operation
- Register-file contract: a read issued in cycle N with wb_en=0 gives rf_read_data in cycle N+1. A read with wb_en=1 in cycle N is dropped, and rf_read_data is unchanged.
- Index 0 is never read. The operand is forced to 0.
- FSM states: IDLE, RD1, RD2, LAST, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch rs1, rs2, use_rs2 and pc, then go to RD1.
- RD1:
  - Issue a read of rs1 if rs1≠0.
  - If the read was issued and wb_en=1, stay in RD1. Otherwise go to RD2.
- RD2:
  - In the first RD2 cycle, capture op1 from rf_read_data, or 0 if rs1=0.
  - If use_rs2=1 and rs2≠0, issue a read of rs2. On wb_en=1 stay in RD2. Otherwise go to LAST.
  - If no rs2 read is needed, set op2=0 and go to DONE.
- LAST: capture op2 from rf_read_data, go to DONE. No read is issued.
- DONE:
  - out_valid=1.
  - in_ready=out_ready.
  - On out_ready with in_valid, latch the new instruction and go to RD1.
  - On out_ready without in_valid, go to IDLE.
  - Outputs hold stable while out_ready=0.
- While rst is low, in_ready=0.

## Timing
- Reset values:
  - out_valid=0, rf_read_en=0, rf_read_reg=0.
  - out_rs1_data, out_rs2_data and out_pc are all 0.
  - State is IDLE.
- Latency with two reads and no conflict: acceptance edge at cycle 0, RD1 in cycle 1, RD2 in cycle 2, LAST in cycle 3, out_valid in cycle 4.
- Each wb_en conflict on an issued read adds 1 cycle.
- rs2 not used, or rs2=0: out_valid in cycle 3.
- Throughput is one instruction per 4 cycles when there are no conflicts.
- rf_read_en and rf_read_reg are combinational from state and latched indices.
- Reset asserted mid-operation aborts immediately. No read is issued after the asynchronous assert.

## Configuration
- OPF_BYPASS_EN defined, writeback forwarding is enabled:
  - In RD1 or RD2, if wb_en=1 and wb_reg equals the index being read (≠0), take wb_data as the operand and proceed without retry.
  - In any state after an operand is captured, including DONE, a matching writeback overwrites the captured operand.
  - A same-cycle writeback beats a capture from rf_read_data.
- OPF_BYPASS_EN undefined:
  - Conflicts always retry.
  - Captured operands are never updated. RAW hazards after capture are the responsibility of the upstream stall logic.

## Structure
- Shared package riscv_core_pkg holds:
  - XLEN and REG_AW.
  - opf_state_t: IDLE, RD1, RD2, LAST, DONE.
- One sub-module, opf_bypass_mux, is compiled only under OPF_BYPASS_EN.
  - Inputs: index, captured value, wb_en, wb_reg, wb_data.
  - Output: the next operand value.
  - It is instantiated twice, once per operand.

## Test plan
- Reset, then offer rs1=3 (0x11), rs2=4 (0x22), use_rs2=1, out_ready=1 → out_valid in cycle 4 with rs1 data 0x11 and rs2 data 0x22. Reads observed: reg 3 in cycle 1, reg 4 in cycle 2.
- rs1=0, rs2=0, use_rs2=1 → no rf_read_en pulses. out_valid in cycle 3 with both operands 0.
- wb_en=1 with wb_reg=9 during the RD1 read of rs1=5 → RD1 repeats once, out_valid in cycle 5, operand equals the register-file value of reg 5.
- With OPF_BYPASS_EN, wb_en=1, wb_reg=5, wb_data=0xDEAD during the rs1=5 read → no retry, rs1 data 0xDEAD, out_valid in cycle 4. The same write in DONE updates out_rs1_data to 0xDEAD.
- out_ready held at 0 for 3 cycles in DONE → outputs stable. Then out_ready=1 with in_valid=1 → back-to-back acceptance, next reads start the following cycle.
- Assert rst while in RD2 → out_valid and rf_read_en drop to 0 immediately. After release, in_ready=1 and the FSM is in IDLE.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: widths and operand-fetch state encoding shared by the core.
package riscv_core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    LAST = 3'd3,
    DONE = 3'd4
  } opf_state_t;

  // True when this cycle's writeback targets idx; register 0 never matches.
  function automatic logic wb_hits(input logic             en,
                                   input logic [REG_AW-1:0] wreg,
                                   input logic [REG_AW-1:0] idx);
    return en && (idx != {REG_AW{1'b0}}) && (wreg == idx);
  endfunction

endpackage

// File: rtl/opf_bypass_mux.sv
// opf_bypass_mux: replaces a captured operand with same-cycle writeback data
// when the writeback targets that operand's register.
// Only present when OPF_BYPASS_EN is defined.
`ifdef OPF_BYPASS_EN
module opf_bypass_mux
  import riscv_core_pkg::*;
(
  input  logic [REG_AW-1:0] i_idx,
  input  logic [XLEN-1:0]   i_cur,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_reg,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic [XLEN-1:0]   o_next
);

  // Writeback data wins over the current/captured value on an index match.
  always_comb begin
    o_next = i_cur;
    if (wb_hits(i_wb_en, i_wb_reg, i_idx)) begin
      o_next = i_wb_data;
    end else begin
      o_next = i_cur;
    end
  end

endmodule
`endif

// File: rtl/operand_fetch.sv
// operand_fetch: sequences rs1/rs2 reads through a single register-file read
// port, retrying reads dropped by a concurrent writeback, and hands the
// operands to execute over valid/ready.
// Optional feature macro: OPF_BYPASS_EN (writeback forwarding into operands).
module operand_fetch
  import riscv_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs2,
  input  logic [XLEN-1:0]   in_pc,
  output logic              rf_read_en,
  output logic [REG_AW-1:0] rf_read_reg,
  input  logic [XLEN-1:0]   rf_read_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_pc
);

  opf_state_t        r_state;
  opf_state_t        w_state_nxt;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic              r_use_rs2;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic              r_op1_cap;
  logic              r_op2_cap;
  logic              r_first_rd2;

  logic              w_accept;
  logic              w_need1;
  logic              w_need2;
  logic              w_hit1;
  logic              w_hit2;
  logic [XLEN-1:0]   w_op1_base;
  logic [XLEN-1:0]   w_op2_base;
  logic [XLEN-1:0]   w_op1_mux;
  logic [XLEN-1:0]   w_op2_mux;
  logic [XLEN-1:0]   w_op1_nxt;
  logic [XLEN-1:0]   w_op2_nxt;
  logic              w_op1_cap_nxt;
  logic              w_op2_cap_nxt;

  assign w_need1 = (r_rs1 != {REG_AW{1'b0}});
  assign w_need2 = r_use_rs2 && (r_rs2 != {REG_AW{1'b0}});

`ifdef OPF_BYPASS_EN
  logic [REG_AW-1:0] w_idx2;
  // An unused rs2 must never pick up writeback data, so its index reads as 0.
  assign w_idx2 = r_use_rs2 ? r_rs2 : {REG_AW{1'b0}};
  assign w_hit1 = wb_hits(wb_en, wb_reg, r_rs1);
  assign w_hit2 = wb_hits(wb_en, wb_reg, w_idx2);

  opf_bypass_mux u_byp_op1 (
    .i_idx(r_rs1), .i_cur(w_op1_base), .i_wb_en(wb_en),
    .i_wb_reg(wb_reg), .i_wb_data(wb_data), .o_next(w_op1_mux)
  );
  opf_bypass_mux u_byp_op2 (
    .i_idx(w_idx2), .i_cur(w_op2_base), .i_wb_en(wb_en),
    .i_wb_reg(wb_reg), .i_wb_data(wb_data), .o_next(w_op2_mux)
  );
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_reg, wb_data};
  assign w_hit1      = 1'b0;
  assign w_hit2      = 1'b0;
  assign w_op1_mux   = w_op1_base;
  assign w_op2_mux   = w_op2_base;
`endif

  // Operands only follow writebacks once an instruction is in flight.
  assign w_op1_nxt = (r_state == IDLE) ? w_op1_base : w_op1_mux;
  assign w_op2_nxt = (r_state == IDLE) ? w_op2_base : w_op2_mux;

  // Next state, acceptance and operand capture selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_op1_base    = r_op1;
    w_op2_base    = r_op2;
    w_op1_cap_nxt = r_op1_cap;
    w_op2_cap_nxt = r_op2_cap;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RD1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD1: begin
        // A forwarded hit counts as the capture of op1; a plain conflict retries.
        if (w_need1 && wb_en && !w_hit1) begin
          w_state_nxt = RD1;
        end else begin
          w_state_nxt = RD2;
        end
        if (w_hit1) begin
          w_op1_cap_nxt = 1'b1;
        end else begin
          w_op1_cap_nxt = r_op1_cap;
        end
      end
      RD2: begin
        if (r_first_rd2 && !r_op1_cap) begin
          w_op1_base    = w_need1 ? rf_read_data : {XLEN{1'b0}};
          w_op1_cap_nxt = 1'b1;
        end else begin
          w_op1_base    = r_op1;
        end
        if (w_need2) begin
          if (wb_en && !w_hit2) begin
            w_state_nxt = RD2;
          end else begin
            w_state_nxt = LAST;
          end
          if (w_hit2) begin
            w_op2_cap_nxt = 1'b1;
          end else begin
            w_op2_cap_nxt = r_op2_cap;
          end
        end else begin
          w_op2_base    = {XLEN{1'b0}};
          w_op2_cap_nxt = 1'b1;
          w_state_nxt   = DONE;
        end
      end
      LAST: begin
        if (!r_op2_cap) begin
          w_op2_base    = rf_read_data;
          w_op2_cap_nxt = 1'b1;
        end else begin
          w_op2_base    = r_op2;
        end
        w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready && in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RD1;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Read port request: rs1 in RD1, rs2 in RD2, never for register 0.
  always_comb begin
    rf_read_en  = 1'b0;
    rf_read_reg = {REG_AW{1'b0}};
    case (r_state)
      RD1: begin
        rf_read_en  = w_need1;
        rf_read_reg = w_need1 ? r_rs1 : {REG_AW{1'b0}};
      end
      RD2: begin
        rf_read_en  = w_need2;
        rf_read_reg = w_need2 ? r_rs2 : {REG_AW{1'b0}};
      end
      default: begin
        rf_read_en  = 1'b0;
        rf_read_reg = {REG_AW{1'b0}};
      end
    endcase
  end

  // Upstream handshake: free in IDLE, pass-through of out_ready in DONE.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = 1'b0;
    end else if (r_state == IDLE) begin
      in_ready = 1'b1;
    end else if (r_state == DONE) begin
      in_ready = out_ready;
    end else begin
      in_ready = 1'b0;
    end
  end

  // State, latched instruction fields and captured operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rs1       <= {REG_AW{1'b0}};
      r_rs2       <= {REG_AW{1'b0}};
      r_use_rs2   <= 1'b0;
      r_pc        <= {XLEN{1'b0}};
      r_op1       <= {XLEN{1'b0}};
      r_op2       <= {XLEN{1'b0}};
      r_op1_cap   <= 1'b0;
      r_op2_cap   <= 1'b0;
      r_first_rd2 <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_first_rd2 <= (r_state == RD1) && (w_state_nxt == RD2);
      r_op1       <= w_op1_nxt;
      r_op2       <= w_op2_nxt;
      if (w_accept) begin
        r_rs1     <= in_rs1;
        r_rs2     <= in_rs2;
        r_use_rs2 <= in_use_rs2;
        r_pc      <= in_pc;
        r_op1_cap <= 1'b0;
        r_op2_cap <= 1'b0;
      end else begin
        r_op1_cap <= w_op1_cap_nxt;
        r_op2_cap <= w_op2_cap_nxt;
      end
    end
  end

  assign out_valid    = (r_state == DONE);
  assign out_rs1_data = r_op1;
  assign out_rs2_data = r_op2;
  assign out_pc       = r_pc;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized and directed checks of operand_fetch against a
// register-file environment model and latency/operand rules.
module tb_operand_fetch;
  import riscv_core_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic              in_use_rs2;
  logic [XLEN-1:0]   in_pc;
  logic              rf_read_en;
  logic [REG_AW-1:0] rf_read_reg;
  logic [XLEN-1:0]   rf_read_data;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_pc;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0]   rf_mem [0:31];
  logic              rf_init;
  logic [REG_AW-1:0] rd_seen [$];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs2(in_use_rs2), .in_pc(in_pc),
    .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_pc(out_pc)
  );

  // Register file: writes always land, reads are dropped under a write.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'd0 : $urandom;
      rf_read_data <= 32'd0;
    end else begin
      if (wb_en && wb_reg != 5'd0) rf_mem[wb_reg] <= wb_data;
      if (rf_read_en && !wb_en) rf_read_data <= rf_mem[rf_read_reg];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    wb_en = 1'b1; wb_reg = idx; wb_data = val;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  // Offers one instruction from IDLE and runs it to out_valid. Writebacks to
  // wbreg are placed on exactly c1 rs1-read cycles and c2 rs2-read cycles.
  task automatic run_txn(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                         input logic [31:0] pc, input int c1, input int c2,
                         input logic [4:0] wbreg, input logic [31:0] wbdata,
                         output int done_cyc, output logic [31:0] d1,
                         output logic [31:0] d2, output logic [31:0] dpc);
    logic n1, n2, wb_now;
    int c1e, c2e;
    n1 = (rs1 != 5'd0);
    n2 = use2 && (rs2 != 5'd0);
    c1e = n1 ? c1 : 0;
    c2e = n2 ? c2 : 0;
    rd_seen.delete();
    done_cyc = -1; d1 = 32'd0; d2 = 32'd0; dpc = 32'd0;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_use_rs2 = use2; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      wb_now = (n1 && k <= c1e) || (n2 && k >= 2 + c1e && k < 2 + c1e + c2e);
      wb_en = wb_now; wb_reg = wbreg; wb_data = wbdata;
      if (rf_read_en) rd_seen.push_back(rf_read_reg);
      if (out_valid) begin
        done_cyc = k; d1 = out_rs1_data; d2 = out_rs2_data; dpc = out_pc;
        wb_en = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    wb_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; rf_init = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (rf_read_en !== 1'b0) begin bad++; $display("FAIL reset_rf_read_en got=%b want=0", rf_read_en); end
    total++; if (rf_read_reg !== 5'd0) begin bad++; $display("FAIL reset_rf_read_reg got=%0d want=0", rf_read_reg); end
    total++; if ({out_rs1_data, out_rs2_data, out_pc} !== 96'd0) begin bad++;
      $display("FAIL reset_outputs got=%h/%h/%h want=0", out_rs1_data, out_rs2_data, out_pc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; rf_init = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic;
    int dc; logic [31:0] d1, d2, dp;
    set_reg(5'd3, 32'h11);
    set_reg(5'd4, 32'h22);
    run_txn(5'd3, 5'd4, 1'b1, 32'h1000, 0, 0, 5'd1, 32'd0, dc, d1, d2, dp);
    total++; if (dc != 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", dc); end
    total++; if (rd_seen.size() != 2 || rd_seen[0] != 5'd3 || rd_seen[1] != 5'd4) begin bad++;
      $display("FAIL basic_reads got=%p want=3,4", rd_seen); end
    total++; if (d1 !== 32'h11 || d2 !== 32'h22 || dp !== 32'h1000) begin bad++;
      $display("FAIL basic_data got=%h/%h/%h want=11/22/1000", d1, d2, dp); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_regs;
    int dc; logic [31:0] d1, d2, dp;
    run_txn(5'd0, 5'd0, 1'b1, 32'h2000, 0, 0, 5'd1, 32'd0, dc, d1, d2, dp);
    total++; if (dc != 3) begin bad++; $display("FAIL zero_latency got=%0d want=3", dc); end
    total++; if (rd_seen.size() != 0) begin bad++; $display("FAIL zero_reads got=%0d reads want=0", rd_seen.size()); end
    total++; if (d1 !== 32'd0 || d2 !== 32'd0) begin bad++; $display("FAIL zero_data got=%h/%h want=0/0", d1, d2); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict_retry;
    int dc; logic [31:0] d1, d2, dp;
    set_reg(5'd5, 32'h55);
    run_txn(5'd5, 5'd4, 1'b1, 32'h3000, 1, 0, 5'd9, 32'h9999, dc, d1, d2, dp);
    total++; if (dc != 5) begin bad++; $display("FAIL retry_latency got=%0d want=5", dc); end
    total++; if (rd_seen.size() != 3 || rd_seen[0] != 5'd5 || rd_seen[1] != 5'd5 || rd_seen[2] != 5'd4) begin bad++;
      $display("FAIL retry_reads got=%p want=5,5,4", rd_seen); end
    total++; if (d1 !== 32'h55 || d2 !== 32'h22) begin bad++; $display("FAIL retry_data got=%h/%h want=55/22", d1, d2); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass;
    int dc; logic [31:0] d1, d2, dp;
    int exp_dc; int exp_n; logic [31:0] exp_done_op;
`ifdef OPF_BYPASS_EN
    exp_dc = 4; exp_n = 2; exp_done_op = 32'hBEEF;
`else
    exp_dc = 5; exp_n = 3; exp_done_op = 32'hDEAD;
`endif
    out_ready = 1'b0;
    run_txn(5'd5, 5'd4, 1'b1, 32'h4000, 1, 0, 5'd5, 32'hDEAD, dc, d1, d2, dp);
    total++; if (dc != exp_dc) begin bad++; $display("FAIL wb_same_reg_latency got=%0d want=%0d", dc, exp_dc); end
    total++; if (rd_seen.size() != exp_n) begin bad++; $display("FAIL wb_same_reg_reads got=%0d want=%0d", rd_seen.size(), exp_n); end
    total++; if (d1 !== 32'hDEAD) begin bad++; $display("FAIL wb_same_reg_op1 got=%h want=dead", d1); end
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hBEEF;
    @(posedge clk); #1;
    wb_en = 1'b0;
    total++; if (out_valid !== 1'b1 || out_rs1_data !== exp_done_op) begin bad++;
      $display("FAIL wb_in_done got=%b/%h want=1/%h", out_valid, out_rs1_data, exp_done_op); end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int dc; int k2; logic [31:0] d1, d2, dp, e1, e2, e3, e4;
    e1 = rf_mem[7]; e2 = rf_mem[8]; e3 = rf_mem[10]; e4 = rf_mem[11];
    out_ready = 1'b0;
    run_txn(5'd7, 5'd8, 1'b1, 32'h5000, 0, 0, 5'd1, 32'd0, dc, d1, d2, dp);
    total++; if (dc != 4 || d1 !== e1 || d2 !== e2) begin bad++;
      $display("FAIL stall_first got=%0d/%h/%h want=4/%h/%h", dc, d1, d2, e1, e2); end
    for (int s = 0; s < 3; s++) begin
      wb_en = 1'b1; wb_reg = 5'd20; wb_data = $urandom;
      @(posedge clk); #1;
      wb_en = 1'b0;
      total++; if (out_valid !== 1'b1 || out_rs1_data !== e1 || out_rs2_data !== e2 || out_pc !== 32'h5000) begin bad++;
        $display("FAIL stall_hold got=%b/%h/%h/%h want=1/%h/%h/5000", out_valid, out_rs1_data, out_rs2_data, out_pc, e1, e2); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    end
    out_ready = 1'b1; in_valid = 1'b1; in_rs1 = 5'd10; in_rs2 = 5'd11; in_use_rs2 = 1'b1; in_pc = 32'h6000;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (rf_read_en !== 1'b1 || rf_read_reg !== 5'd10) begin bad++;
      $display("FAIL b2b_first_read got=%b/%0d want=1/10", rf_read_en, rf_read_reg); end
    k2 = -1;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid) begin k2 = k; break; end
      @(posedge clk); #1;
    end
    total++; if (k2 != 4 || out_rs1_data !== e3 || out_rs2_data !== e4 || out_pc !== 32'h6000) begin bad++;
      $display("FAIL b2b_second got=%0d/%h/%h/%h want=4/%h/%h/6000", k2, out_rs1_data, out_rs2_data, out_pc, e3, e4); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int dc; logic [31:0] d1, d2, dp;
    logic [4:0] rs1, rs2, wr; logic use2; logic [31:0] pc;
    int c1, c2, exp_dc, exp_n; logic [31:0] e1, e2;
    for (int it = 0; it < 25; it++) begin
      rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      use2 = 1'($urandom_range(0, 1));
      pc = $urandom;
      c1 = $urandom_range(0, 2); c2 = $urandom_range(0, 2);
      wr = 5'($urandom_range(1, 31));
      while (wr == rs1 || wr == rs2) wr = 5'($urandom_range(1, 31));
      e1 = (rs1 == 5'd0) ? 32'd0 : rf_mem[rs1];
      e2 = (use2 && rs2 != 5'd0) ? rf_mem[rs2] : 32'd0;
      exp_dc = 3 + ((use2 && rs2 != 5'd0) ? 1 + c2 : 0) + ((rs1 != 5'd0) ? c1 : 0);
      exp_n  = ((rs1 != 5'd0) ? 1 + c1 : 0) + ((use2 && rs2 != 5'd0) ? 1 + c2 : 0);
      run_txn(rs1, rs2, use2, pc, c1, c2, wr, $urandom, dc, d1, d2, dp);
      total++; if (dc != exp_dc) begin bad++; $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, dc, exp_dc); end
      total++; if (rd_seen.size() != exp_n) begin bad++; $display("FAIL rand_reads it=%0d got=%0d want=%0d", it, rd_seen.size(), exp_n); end
      total++; if (d1 !== e1 || d2 !== e2 || dp !== pc) begin bad++;
        $display("FAIL rand_data it=%0d got=%h/%h/%h want=%h/%h/%h", it, d1, d2, dp, e1, e2, pc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    int dc; logic [31:0] d1, d2, dp;
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_use_rs2 = 1'b1; in_pc = 32'h7000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (rf_read_en !== 1'b1 || rf_read_reg !== 5'd4) begin bad++;
      $display("FAIL mid_rd2_read got=%b/%0d want=1/4", rf_read_en, rf_read_reg); end
    #2 rst = 1'b0;
    #1;
    total++; if (rf_read_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++;
      $display("FAIL mid_reset_drop got=%b/%b/%b want=0/0/0", rf_read_en, out_valid, in_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_read_en !== 1'b0) begin bad++;
      $display("FAIL mid_reset_idle got=%b/%b/%b want=1/0/0", in_ready, out_valid, rf_read_en); end
    run_txn(5'd0, 5'd0, 1'b0, 32'h8000, 0, 0, 5'd1, 32'd0, dc, d1, d2, dp);
    total++; if (dc != 3 || dp !== 32'h8000) begin bad++; $display("FAIL mid_reset_resume got=%0d/%h want=3/8000", dc, dp); end
    @(posedge clk); #1;
  endtask

  initial begin
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_use_rs2 = 1'b0; in_pc = 32'd0;
    wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
    test_reset;
    test_basic;
    test_zero_regs;
    test_conflict_retry;
    test_bypass;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
